// File: rtl/dmem_ctrl.sv
// Multi-cycle data-memory controller: byte-enabled RAM, wait-state latency, req/ready handshake,
// error signalling, and two MMIO words (output register and free-running cycle counter).
module dmem_ctrl #(
    parameter int unsigned ADDR_W    = 6,
    parameter int unsigned LATENCY   = 2,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  byteen,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        err,
    output logic [31:0] out_reg,
    output logic        busy
);

    localparam logic [31:0] RamBytes = 32'(4 * (2 ** ADDR_W));
    localparam logic [3:0]  LatCnt   = 4'(LATENCY);
    localparam logic [31:0] CntAddr  = MMIO_BASE + 32'd4;

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [31:0] out_reg_q, out_reg_d;
    logic [31:0] cyc_q, cyc_d;

    logic [31:0] mem [2**ADDR_W];

    logic              commit;
    logic              c_we;
    logic [31:0]       c_addr, c_wdata;
    logic [3:0]        c_be;
    logic [ADDR_W-1:0] ram_idx;
    logic              is_mis, is_ram, is_out, is_cnt, bad;
    logic              ram_wr;
    logic [31:0]       ram_word;

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] res;
        res = old_w;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
        end
        return res;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        commit  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    we_d    = we;
                    addr_d  = addr;
                    wdata_d = wdata;
                    be_d    = byteen;
                    cnt_d   = LatCnt;
                    if (LATENCY == 0) begin
                        state_d = StDone;
                        commit  = 1'b1;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = StDone;
                    commit  = 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Zero latency commits on the accept edge, so the request fields bypass the latches there.
    always_comb begin
        c_we    = (state_q == StIdle) ? we     : we_q;
        c_addr  = (state_q == StIdle) ? addr   : addr_q;
        c_wdata = (state_q == StIdle) ? wdata  : wdata_q;
        c_be    = (state_q == StIdle) ? byteen : be_q;
        ram_idx = c_addr[ADDR_W+1:2];
        is_mis  = (c_addr[1:0] != 2'b00);
        is_ram  = (c_addr < RamBytes);
        is_out  = (c_addr == MMIO_BASE);
        is_cnt  = (c_addr == CntAddr);
        bad     = is_mis || !(is_ram || is_out || is_cnt);
        ram_word = mem[ram_idx];
        ram_wr   = commit && c_we && is_ram && !bad;
    end

    always_comb begin
        rdata_d   = rdata_q;
        out_reg_d = out_reg_q;
        err_d     = 1'b0;
        cyc_d     = cyc_q + 32'd1;
        if (commit) begin
            err_d = bad;
            if (bad) begin
                rdata_d = 32'd0;
            end else if (c_we) begin
                if (is_out) out_reg_d = merge(out_reg_q, c_wdata, c_be);
            end else if (is_ram) begin
                rdata_d = ram_word;
            end else if (is_out) begin
                rdata_d = out_reg_q;
            end else begin
                rdata_d = cyc_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            we_q      <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            be_q      <= 4'd0;
            rdata_q   <= 32'd0;
            err_q     <= 1'b0;
            out_reg_q <= 32'd0;
            cyc_q     <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            out_reg_q <= out_reg_d;
            cyc_q     <= cyc_d;
        end
    end

    // RAM is never cleared; reset only blocks a write that would land on the same edge.
    always_ff @(posedge clk) begin
        if (reset && ram_wr) mem[ram_idx] <= merge(ram_word, c_wdata, c_be);
    end

    assign ready   = (state_q == StDone);
    assign busy    = (state_q != StIdle);
    assign rdata   = rdata_q;
    assign err     = err_q;
    assign out_reg = out_reg_q;

endmodule
